imul_int_mul_param: RTL and testbench

Parametrised iterative shift-add integer multiplier, the successor to the fixed 32-bit base multiplier in the lab1_imul family. It accepts two NBITS-bit unsigned operands and a mode bit over a val/rdy stream, and computes the full 2*NBITS-bit product in a 2*NBITS accumulator. It returns either the low or the high half of the product. It can also terminate early once the remaining multiplier bits are zero. It sits behind the same val/rdy source/sink harness as the other imul variants.

---
 rtl/imul_pkg.sv | 14 +
 rtl/imul_int_mul_param_dpath.sv | 71 +++++++
 rtl/vc_EnResetReg.sv | 20 ++
 rtl/vc_Mux2.sv | 13 +
 rtl/imul_int_mul_param.sv | 81 ++++++++
 tb/tb_imul_int_mul_param.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/imul_pkg.sv
// Shared types and constants for the imul multiplier family: FSM state
// encoding and the result-half select values.
package imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic IMUL_MODE_LO = 1'b0;
  localparam logic IMUL_MODE_HI = 1'b1;

endpackage

// File: rtl/imul_int_mul_param_dpath.sv
// Shift-add multiplier datapath: operand shifters, 2*NBITS accumulator and
// result-half select. Zero-detect of the remaining multiplier bits exists
// only when IMUL_EARLY_EXIT_EN is defined.
module imul_int_mul_param_dpath #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*NBITS-1:0] istream_msg,
  input  logic               istream_mode,
  input  logic               load,
  input  logic               calc,
  input  logic               add_en,
  output logic               b_lsb,
  output logic               b_rest_zero,
  output logic [NBITS-1:0]   ostream_msg
);

  import imul_pkg::*;

  logic [2*NBITS-1:0] a_reg, a_next, a_init, a_shl;
  logic [NBITS-1:0]   b_reg, b_next, b_init, b_shr;
  logic [2*NBITS-1:0] acc, acc_next, acc_sum;
  logic               mode_reg;

  assign a_init = {{NBITS{1'b0}}, istream_msg[2*NBITS-1:NBITS]};
  assign a_shl  = {a_reg[2*NBITS-2:0], 1'b0};
  assign b_init = istream_msg[NBITS-1:0];
  assign b_shr  = {1'b0, b_reg[NBITS-1:1]};
  // Full-width add; a carry out of the top bit is dropped.
  assign acc_sum = acc + a_reg;

  vc_Mux2 #(.p_nbits(2*NBITS)) a_mux (
    .in0(a_shl), .in1(a_init), .sel(load), .out(a_next)
  );
  vc_EnResetReg #(.p_nbits(2*NBITS)) a_reg_q (
    .clk(clk), .reset(reset), .q(a_reg), .d(a_next), .en(load | calc)
  );

  vc_Mux2 #(.p_nbits(NBITS)) b_mux (
    .in0(b_shr), .in1(b_init), .sel(load), .out(b_next)
  );
  vc_EnResetReg #(.p_nbits(NBITS)) b_reg_q (
    .clk(clk), .reset(reset), .q(b_reg), .d(b_next), .en(load | calc)
  );

  vc_Mux2 #(.p_nbits(2*NBITS)) acc_mux (
    .in0(acc_sum), .in1({2*NBITS{1'b0}}), .sel(load), .out(acc_next)
  );
  vc_EnResetReg #(.p_nbits(2*NBITS)) acc_q (
    .clk(clk), .reset(reset), .q(acc), .d(acc_next), .en(load | add_en)
  );

  vc_EnResetReg #(.p_nbits(1)) mode_q (
    .clk(clk), .reset(reset), .q(mode_reg), .d(istream_mode), .en(load)
  );

  vc_Mux2 #(.p_nbits(NBITS)) out_mux (
    .in0(acc[NBITS-1:0]), .in1(acc[2*NBITS-1:NBITS]),
    .sel(mode_reg == IMUL_MODE_HI), .out(ostream_msg)
  );

  assign b_lsb = b_reg[0];

`ifdef IMUL_EARLY_EXIT_EN
  assign b_rest_zero = ~|b_reg[NBITS-1:1];
`else
  assign b_rest_zero = 1'b0;
`endif

endmodule

// File: rtl/vc_EnResetReg.sv
// Enabled register primitive with synchronous active-high reset to a
// parameterised value.
module vc_EnResetReg #(
  parameter int                 p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [p_nbits-1:0] q,
  input  logic [p_nbits-1:0] d,
  input  logic               en
);

  // NOTE: non-blocking so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset)   q <= p_reset_value;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vc_Mux2.sv
// Two-input multiplexer primitive from the vc component library.
module vc_Mux2 #(
  parameter int p_nbits = 1
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic               sel,
  output logic [p_nbits-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/imul_int_mul_param.sv
// Parametrised iterative shift-add multiplier with val/rdy streams: FSM and
// iteration counter. Define IMUL_EARLY_EXIT_EN for data-dependent latency.
module imul_int_mul_param #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  input  logic               istream_mode,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [NBITS-1:0]   ostream_msg
);

  import imul_pkg::*;

  localparam int             CW       = $clog2(NBITS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NBITS - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          load, calc, add_en;
  logic          b_lsb, b_rest_zero;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The increment past CNT_LAST is never observed: CALC exits on that cycle.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (calc) cnt <= cnt + 1'b1;
  end

  always_comb begin
    // NOTE: defaults first so no branch leaves a signal unassigned (no latch).
    state_next  = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    load        = 1'b0;
    calc        = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (cnt == CNT_LAST || b_rest_zero) state_next = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign add_en = calc & b_lsb;

  imul_int_mul_param_dpath #(.NBITS(NBITS)) dpath (
    .clk          (clk),
    .reset        (reset),
    .istream_msg  (istream_msg),
    .istream_mode (istream_mode),
    .load         (load),
    .calc         (calc),
    .add_en       (add_en),
    .b_lsb        (b_lsb),
    .b_rest_zero  (b_rest_zero),
    .ostream_msg  (ostream_msg)
  );

endmodule

// File: tb/tb_imul_int_mul_param.sv
// Directed-vector bench for imul_int_mul_param at NBITS=32 and NBITS=8;
// expected latencies follow IMUL_EARLY_EXIT_EN.
module tb_imul_int_mul_param;

`ifdef IMUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ival, irdy, imode, ovl, ordy;
  logic [63:0] imsg;
  logic [31:0] omsg;

  logic        ival8, irdy8, imode8, ovl8, ordy8;
  logic [15:0] imsg8;
  logic [7:0]  omsg8;

  imul_int_mul_param #(.NBITS(32)) dut32 (
    .clk(clk), .reset(reset),
    .istream_val(ival), .istream_rdy(irdy), .istream_msg(imsg),
    .istream_mode(imode),
    .ostream_val(ovl), .ostream_rdy(ordy), .ostream_msg(omsg)
  );

  imul_int_mul_param #(.NBITS(8)) dut8 (
    .clk(clk), .reset(reset),
    .istream_val(ival8), .istream_rdy(irdy8), .istream_msg(imsg8),
    .istream_mode(imode8),
    .ostream_val(ovl8), .ostream_rdy(ordy8), .ostream_msg(omsg8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
    logic [31:0] exp;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic mode,
                         input string name);
    ival  = 1'b1;
    imsg  = {a, b};
    imode = mode;
    check({name, " accept rdy"}, {63'd0, irdy}, 64'd1);
    tick();
    ival = 1'b0;
  endtask

  // Latency counts edges from the accept edge up to the first one after
  // which ostream_val is seen high.
  task automatic wait32(output int lat);
    lat = 1;
    while (ovl !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish32();
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic mode,
                       input logic [31:0] exp, input int lat_f, input int lat_e,
                       input string name);
    int lat;
    start32(a, b, mode, name);
    wait32(lat);
    check({name, " msg"}, {32'd0, omsg}, {32'd0, exp});
    check({name, " latency"}, 64'(lat), 64'(EARLY ? lat_e : lat_f));
    finish32();
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic mode,
                      input logic [7:0] exp, input int exp_lat, input string name);
    int lat;
    ival8  = 1'b1;
    imsg8  = {a, b};
    imode8 = mode;
    check({name, " accept rdy"}, {63'd0, irdy8}, 64'd1);
    tick();
    ival8 = 1'b0;
    lat = 1;
    while (ovl8 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check({name, " msg"}, {56'd0, omsg8}, {56'd0, exp});
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious;
    int lat;

    vecs[0]  = '{32'd3,        32'd4,        1'b0, 32'd12,       33, 4};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 33, 33};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 33, 33};
    vecs[3]  = '{32'h12345678, 32'h00000000, 1'b0, 32'h00000000, 33, 2};
    vecs[4]  = '{32'h12345678, 32'h00000001, 1'b0, 32'h12345678, 33, 2};
    vecs[5]  = '{32'h12345678, 32'h80000000, 1'b1, 32'h091A2B3C, 33, 33};
    vecs[6]  = '{32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 33, 18};
    vecs[7]  = '{32'h00010000, 32'h00010000, 1'b0, 32'h00000000, 33, 18};
    vecs[8]  = '{32'hDEADBEEF, 32'h00000002, 1'b1, 32'h00000001, 33, 3};
    vecs[9]  = '{32'hDEADBEEF, 32'h00000002, 1'b0, 32'hBD5B7DDE, 33, 3};
    vecs[10] = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFF1, 33, 4};

    reset = 1'b1;
    ival = 1'b0; imsg = '0; imode = 1'b0; ordy = 1'b0;
    ival8 = 1'b0; imsg8 = '0; imode8 = 1'b0; ordy8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset irdy",  {63'd0, irdy},  64'd1);
    check("reset ovl",   {63'd0, ovl},   64'd0);
    check("reset omsg",  {32'd0, omsg},  64'd0);
    check("reset irdy8", {63'd0, irdy8}, 64'd1);
    check("reset ovl8",  {63'd0, ovl8},  64'd0);

    for (int i = 0; i < NV; i++)
      run32(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp,
            vecs[i].lat_fixed, vecs[i].lat_early, $sformatf("vec%0d", i));

    // Back-pressure in DONE: result held, new requests ignored.
    start32(32'd9, 32'd5, 1'b0, "hold");
    wait32(lat);
    check("hold msg", {32'd0, omsg}, 64'd45);
    check("hold latency", 64'(lat), 64'(EARLY ? 4 : 33));
    for (int i = 0; i < 5; i++) begin
      ival = 1'b1;
      imsg = {32'd1, 32'd1};
      tick();
      check($sformatf("hold%0d ovl", i),  {63'd0, ovl},  64'd1);
      check($sformatf("hold%0d omsg", i), {32'd0, omsg}, 64'd45);
      check($sformatf("hold%0d irdy", i), {63'd0, irdy}, 64'd0);
    end
    ival = 1'b0;
    finish32();
    check("after hold irdy", {63'd0, irdy}, 64'd1);
    check("after hold ovl",  {63'd0, ovl},  64'd0);
    run32(32'd6, 32'd7, 1'b0, 32'd42, 33, 4, "after hold");

    // Reset mid-operation discards the in-flight multiply.
    start32(32'd100, 32'd200, 1'b0, "abort");
    repeat (9) tick();
    check("abort busy irdy", {63'd0, irdy}, 64'd0);
    reset = 1'b1;
    tick();
    check("abort irdy", {63'd0, irdy}, 64'd1);
    check("abort ovl",  {63'd0, ovl},  64'd0);
    check("abort omsg", {32'd0, omsg}, 64'd0);
    reset = 1'b0;
    spurious = 0;
    repeat (40) begin
      tick();
      if (ovl === 1'b1) spurious++;
    end
    check("abort no response", 64'(spurious), 64'd0);
    run32(32'd7, 32'd6, 1'b0, 32'd42, 33, 4, "after abort");

    run8(8'hFF, 8'hFF, 1'b1, 8'hFE, 9, "n8 hi");
    run8(8'hFF, 8'hFF, 1'b0, 8'h01, 9, "n8 lo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
